fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined CPU. It owns the PC register and the PC+4 adder, drives the instruction-memory address, and buffers fetched instructions in a DEPTH-entry queue. It replaces the single IF/ID register with a decoupled queue, so fetch continues while decode is stalled. Redirects from the ID stage (branch, jump, jr) flush the queue and restart fetch.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fq_storage.sv | 29 ++
 rtl/fetch_queue.sv | 125 ++++++++++++
 tb/tb_fetch_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and elaboration checks for the instruction-fetch queue.
// Latency: n/a (types only). Backpressure: n/a.
// fq_entry_t is the default-width queue entry; fetch_queue re-declares the same layout at its own widths.
package fetch_pkg;

    localparam int FQ_DATA_W = 32;
    localparam int FQ_ADDR_W = 32;

    typedef struct packed {
        logic [FQ_ADDR_W-1:0] pcplus4;
        logic [FQ_DATA_W-1:0] instr;
    } fq_entry_t;

    localparam int FQ_NOP = 0;

    function automatic bit fqParamsOk(input int depth, input int addrW);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) && (addrW >= 3);
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: one synchronous write port, one asynchronous read port, no reset.
// Latency: write visible on the read port the cycle after the write edge. Backpressure: none, caller gates wrEn.
// Contents are don't-care until written; validity is tracked by the caller's count.
module fq_storage
    import fetch_pkg::*;
#(
    parameter type entry_t = fq_entry_t,
    parameter int  DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wrEn,
    input  logic [PTR_W-1:0] wrPtr,
    input  entry_t           wrData,
    input  logic [PTR_W-1:0] rdPtr,
    output entry_t           rdData
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= wrData;
        end
    end

    assign rdData = mem[rdPtr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC register, PC+4 adder and a DEPTH-entry queue decoupling fetch from decode.
// Latency: 1 cycle fetch-to-head (0 with FETCH_QUEUE_BYPASS_EN on an empty queue); redirect target at head 2 cycles later (1 with bypass).
// Backpressure: deq_ready low lets the queue fill; when full, fetch_pc holds and the same address is re-presented.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              deq_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pcplus4,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pcplus4;
        logic [DATA_W-1:0] instr;
    } entry_t;

    if (!fqParamsOk(DEPTH, ADDR_W)) begin : gBadParams
        $error("fetch_queue: DEPTH must be a power of two >= 2 and ADDR_W >= 3");
    end

    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] pcPlus4;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;
    logic              notEmpty;
    logic              queueDeq;
    logic              fetchOk;
    logic              enq;
    logic              bypass;
    logic              wrEn;
    entry_t            fetchEntry;
    entry_t            headEntry;

    assign pcPlus4  = fetchPc + ADDR_W'(4);
    assign notEmpty = (count != '0);
    // Dequeue is qualified on stored entries only, which keeps the bypass path free of a combinational loop.
    assign queueDeq = notEmpty & deq_ready;
    assign fetchOk  = (count < CNT_W'(DEPTH)) | queueDeq;
    assign enq      = fetchOk & ~redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = ~notEmpty & enq & deq_ready;
`else
    assign bypass = 1'b0;
`endif

    assign wrEn       = enq & ~bypass;
    assign fetchEntry = '{pcplus4: pcPlus4, instr: imem_rdata};

    fq_storage #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) uStorage (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrPtr  (wrPtr),
        .wrData (fetchEntry),
        .rdPtr  (rdPtr),
        .rdData (headEntry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc <= RESET_PC;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else if (redirect_valid) begin
            fetchPc <= redirect_pc;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else begin
            if (enq) begin
                fetchPc <= pcPlus4;
            end
            if (wrEn) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (queueDeq) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= count + CNT_W'(wrEn) - CNT_W'(queueDeq);
        end
    end

    always_comb begin
        out_valid   = 1'b0;
        out_instr   = DATA_W'(FQ_NOP);
        out_pcplus4 = ADDR_W'(FQ_NOP);
        if (notEmpty) begin
            out_valid   = 1'b1;
            out_instr   = headEntry.instr;
            out_pcplus4 = headEntry.pcplus4;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass) begin
            out_valid   = 1'b1;
            out_instr   = fetchEntry.instr;
            out_pcplus4 = fetchEntry.pcplus4;
        end
`endif
    end

    assign imem_addr = fetchPc;
    assign occupancy = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed steps from the block's test plan, then randomized traffic against a queue-based model.
module tb_fetch_queue;

    localparam int          DW       = 32;
    localparam int          AW       = 32;
    localparam int          DEPTH    = 4;
    localparam int          CW       = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] ins;
    } mEntry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          deq_ready = 1'b1;
    logic          out_valid;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pcplus4;
    logic [CW-1:0] occupancy;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mPc;
    mEntry_t     q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0001;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = memWord(imem_addr);

    fetch_queue #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_ready      (deq_ready),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pcplus4    (out_pcplus4),
        .occupancy      (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, compare against the model, advance the model, then take the rising edge.
    task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic dr);
        logic    byp;
        logic    deq;
        logic    ok;
        mEntry_t head;
        mEntry_t fetched;
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        deq_ready      = dr;
        #1;
        fetched.pc4 = mPc + 32'd4;
        fetched.ins = memWord(mPc);
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (q.size() == 0) && !rv && dr;
`else
        byp = 1'b0;
`endif
        check("imem_addr", imem_addr, mPc);
        check("occupancy", 32'(occupancy), 32'(q.size()));
        if (byp) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_instr", out_instr, fetched.ins);
            check("out_pcplus4", out_pcplus4, fetched.pc4);
        end else if (q.size() > 0) begin
            head = q[0];
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_instr", out_instr, head.ins);
            check("out_pcplus4", out_pcplus4, head.pc4);
        end else begin
            check("out_valid", 32'(out_valid), 32'd0);
            check("out_instr", out_instr, 32'd0);
            check("out_pcplus4", out_pcplus4, 32'd0);
        end
        if (r) begin
            q.delete();
            mPc = RESET_PC;
        end else if (rv) begin
            q.delete();
            mPc = rp;
        end else begin
            deq = (q.size() > 0) && dr;
            ok  = (q.size() < DEPTH) || deq;
            if (deq) void'(q.pop_front());
            if (ok) begin
                if (!byp) q.push_back(fetched);
                mPc = mPc + 32'd4;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        logic        r;
        logic        rv;
        logic        dr;
        logic [31:0] rp;

        rst = 1'b1;
        @(posedge clk);
        q.delete();
        mPc = RESET_PC;

        // Reset state and first fetch.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        #2;
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_out_instr", out_instr, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
`ifndef FETCH_QUEUE_BYPASS_EN
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        #2;
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_instr", out_instr, 32'h2008_0001);
        check("first_pcplus4", out_pcplus4, 32'd4);
        check("first_imem_addr", imem_addr, 32'd4);

        // Fill while decode stalls, then drain with no gap across the pointer wrap.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        check("full_occupancy", 32'(occupancy), 32'd4);
        check("full_imem_addr", imem_addr, 32'h10);
        for (int i = 0; i < 5; i++) begin
            check("drain_pcplus4", out_pcplus4, 32'(4 * (i + 1)));
            check("drain_occupancy", 32'(occupancy), 32'd4);
            step(1'b0, 1'b0, 32'h0, 1'b1);
            #2;
        end

        // Redirect flushes a partly filled queue.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        check("pre_redir_occupancy", 32'(occupancy), 32'd3);
        step(1'b0, 1'b1, 32'h40, 1'b0);
        #2;
        check("redir_occupancy", 32'(occupancy), 32'd0);
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_imem_addr", imem_addr, 32'h40);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        check("redir_pcplus4", out_pcplus4, 32'h44);
        check("redir_head_valid", 32'(out_valid), 32'd1);

        // Reset mid-operation discards entries.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        check("pre_rst_occupancy", 32'(occupancy), 32'd2);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        #2;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_occupancy", 32'(occupancy), 32'd0);
        check("midrst_imem_addr", imem_addr, RESET_PC);
`endif

        // Randomized traffic, including redirects to the top of the address space and unaligned targets.
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            rv = ($urandom_range(0, 99) < 10);
            dr = ($urandom_range(0, 99) < 65);
            case ($urandom_range(0, 3))
                0:       rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                1:       rp = 32'h0000_0100 + 32'($urandom_range(0, 63));
                default: rp = $urandom;
            endcase
            step(r, rv, rp, dr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
